// File: rtl/receiver.sv
// rtl/receiver.sv - 802.11a receive descrambler with seed recovery and 7-stage output delay line
module receiver (
    input  logic       Clk,
    input  logic       Reset,
    input  logic       x,
    input  logic [2:0] num_pads,
    output logic       y
);

    // scr[0] is the newest state bit S[1], scr[6] is S[7]
    logic [6:0] scr;
    logic [6:0] scr_next;
    logic [3:0] cnt;
    logic [6:0] dly;
    logic [6:0] vld;
    logic       prefix;
    logic       seq_bit;
    logic       d;
    logic       unused_pads;

    // pad count is carried for a later pad-removal stage and deliberately ignored here
    assign unused_pads = ^num_pads;

    // first seven bits after reset are the all-zero plaintext prefix
    assign prefix  = (cnt < 4'd7);
    assign seq_bit = scr[6] ^ scr[3];

    // descramble: during the prefix the received bit is the sequence itself and seeds the state
    always_comb begin
        d        = 1'b0;
        scr_next = {scr[5:0], seq_bit};
        if (prefix) begin
            scr_next = {scr[5:0], x};
        end else begin
            d = x ^ seq_bit;
        end
    end

    // state, saturating bit counter and delay line; the last stage is loaded masked so y is a pure flop
    always_ff @(posedge Clk) begin
        if (!Reset) begin
            scr <= 7'd0;
            cnt <= 4'd0;
            dly <= 7'd0;
            vld <= 7'd0;
        end else begin
            scr <= scr_next;
            if (prefix) begin
                cnt <= cnt + 4'd1;
            end
            vld <= {vld[5:0], ~prefix};
            dly <= {dly[5] & vld[5], dly[4:0], d};
        end
    end

    assign y = dly[6];

endmodule

// File: tb/tb_receiver.sv
// tb/tb_receiver.sv - randomized self-checking bench for the receive descrambler
module tb_receiver;

    logic       Clk;
    logic       Reset;
    logic       x;
    logic [2:0] num_pads;
    logic       y;

    int checks;
    int errors;

    bit pay  [0:511];
    bit xs   [0:511];
    bit yobs [0:2][0:511];

    receiver dut (
        .Clk      (Clk),
        .Reset    (Reset),
        .x        (x),
        .num_pads (num_pads),
        .y        (y)
    );

    initial Clk = 1'b0;
    always #5 Clk = ~Clk;

    task automatic step();
        @(posedge Clk);
        #1;
    endtask

    // scrambled stream from first 7 sequence bits (MSB = bit 0) via s[n] = s[n-7] ^ s[n-4]
    function automatic void build_x(input bit [6:0] first7, input int len);
        bit seq [0:511];
        for (int n = 0; n < len; n++) begin
            if (n < 7) seq[n] = first7[6 - n];
            else       seq[n] = seq[n - 7] ^ seq[n - 4];
            xs[n] = ((n < 7) ? 1'b0 : pay[n - 7]) ^ seq[n];
        end
    endfunction

    task automatic do_reset(input int edges);
        Reset = 1'b0;
        for (int i = 0; i < edges; i++) begin
            x        = 1'($urandom);
            num_pads = 3'($urandom);
            step();
            checks++;
            if (y !== 1'b0) begin
                errors++;
                $display("FAIL reset_hold edge %0d: y=%b expected 0", i, y);
            end
        end
        Reset = 1'b1;
    endtask

    // drive xs[0..len-1]; y after edge i must be 0 for i<13 else pay[i-13]
    task automatic run_stream(input string name, input int len, input int slot,
                              input bit rnd_pads, input logic [2:0] pads);
        bit expv;
        for (int i = 0; i < len; i++) begin
            x        = xs[i];
            num_pads = rnd_pads ? 3'($urandom) : pads;
            step();
            yobs[slot][i] = y;
            expv = (i < 13) ? 1'b0 : pay[i - 13];
            checks++;
            if (y !== expv) begin
                errors++;
                $display("FAIL %s edge %0d: y=%b expected %b", name, i, y, expv);
            end
        end
    endtask

    task automatic test_reset();
        x = 1'b1;
        num_pads = 3'd5;
        do_reset(2);
        for (int i = 0; i < 13; i++) begin
            x        = 1'($urandom);
            num_pads = 3'($urandom);
            step();
            checks++;
            if (y !== 1'b0) begin
                errors++;
                $display("FAIL reset_release edge %0d: y=%b expected 0", i, y);
            end
        end
    endtask

    task automatic test_zero_payload();
        bit [39:0] lit;
        lit = 40'b0000111011110010110010010000001000100110;
        do_reset(2);
        for (int i = 0; i < 40; i++) begin
            x = lit[39 - i];
            num_pads = 3'd0;
            step();
            checks++;
            if (y !== 1'b0) begin
                errors++;
                $display("FAIL zero_payload edge %0d: y=%b expected 0", i, y);
            end
        end
    endtask

    task automatic test_known_data();
        for (int i = 0; i < 269; i++) pay[i] = 1'($urandom);
        build_x(7'b0000111, 276);
        do_reset(2);
        run_stream("known_data", 276, 0, 1'b0, 3'd0);
        // same idea with a random non-zero seed
        for (int i = 0; i < 200; i++) pay[i] = 1'($urandom);
        build_x(7'($urandom_range(1, 127)), 207);
        do_reset(2);
        run_stream("random_seed", 207, 0, 1'b1, 3'd0);
    endtask

    task automatic test_zero_state();
        bit [9:0] p;
        p = 10'b1011001110;
        for (int i = 0; i < 10; i++) pay[i] = p[9 - i];
        build_x(7'b0000000, 17);
        do_reset(2);
        run_stream("zero_state", 17, 0, 1'b0, 3'd3);
    endtask

    task automatic test_reset_midstream();
        for (int i = 0; i < 93; i++) pay[i] = 1'($urandom);
        build_x(7'($urandom_range(1, 127)), 100);
        do_reset(2);
        run_stream("pre_midreset", 100, 0, 1'b1, 3'd0);
        do_reset(1);
        for (int i = 0; i < 4; i++)  pay[i] = 1'b1;
        for (int i = 4; i < 10; i++) pay[i] = 1'b0;
        build_x(7'b0000000, 17);
        run_stream("post_midreset", 17, 0, 1'b0, 3'd6);
    endtask

    task automatic test_num_pads();
        logic [2:0] padv [0:2];
        padv[0] = 3'd0;
        padv[1] = 3'd1;
        padv[2] = 3'd7;
        for (int i = 0; i < 269; i++) pay[i] = 1'($urandom);
        build_x(7'b0000111, 276);
        for (int k = 0; k < 3; k++) begin
            do_reset(2);
            run_stream("num_pads_run", 276, k, 1'b0, padv[k]);
        end
        for (int k = 1; k < 3; k++) begin
            for (int i = 0; i < 276; i++) begin
                checks++;
                if (yobs[k][i] !== yobs[0][i]) begin
                    errors++;
                    $display("FAIL num_pads_compare pads=%0d edge %0d: y=%b expected %b",
                             padv[k], i, yobs[k][i], yobs[0][i]);
                end
            end
        end
    endtask

    initial begin
        checks   = 0;
        errors   = 0;
        Reset    = 1'b0;
        x        = 1'b0;
        num_pads = 3'd0;
        #1;
        test_reset();
        test_zero_payload();
        test_known_data();
        test_zero_state();
        test_reset_midstream();
        test_num_pads();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
